// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode encodings, FSM state
// enum, and the combinational evaluator for every non-multiply operation.
// alu_comb works on a MAX_W-bit container; the caller passes the active
// operand width, which is a constant at every instantiation.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_NAND = 3'b101;
    localparam logic [2:0] ALU_NOR  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic                 c;
        logic                 v;
        logic [2*MAX_W-1:0]   result;
    } alu_out_t;

    // Result is zero-extended to 2*MAX_W; bit 'width' carries the ADD carry
    // or SUB borrow. MUL is not handled here and yields zero.
    function automatic alu_out_t alu_comb(input logic [2:0]       op,
                                          input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input logic [5:0]       width);
        logic [2*MAX_W-1:0] mask;
        logic [2*MAX_W-1:0] ax;
        logic [2*MAX_W-1:0] bx;
        logic [2*MAX_W-1:0] r;
        logic [5:0]         msb;
        alu_out_t           o;

        mask = (64'd1 << width) - 64'd1;
        ax   = {{MAX_W{1'b0}}, a} & mask;
        bx   = {{MAX_W{1'b0}}, b} & mask;
        msb  = width - 6'd1;
        o    = '0;
        r    = '0;

        case (op)
            ALU_ADD: begin
                r   = ax + bx;
                o.c = r[width];
                o.v = (ax[msb] == bx[msb]) && (r[msb] != ax[msb]);
            end
            ALU_SUB: begin
                r        = (ax - bx) & mask;
                o.v      = (ax[msb] != bx[msb]) && (r[msb] != ax[msb]);
                o.c      = (ax < bx);
                r[width] = o.c;
            end
            ALU_AND:  r = ax & bx;
            ALU_OR:   r = ax | bx;
            ALU_NAND: r = ~(ax & bx) & mask;
            ALU_NOR:  r = ~(ax | bx) & mask;
            ALU_XOR:  r = ax ^ bx;
            default:  r = '0;
        endcase

        o.result = r;
        return o;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// ---------------------------------------------------------------------------
// alu_seq_mul
// Iterative shift-add unsigned multiplier, one partial product per cycle.
//   clk, rst      clock, synchronous active-high reset
//   start         load operands and begin WIDTH iterations
//   a, b          multiplicand / multiplier (sampled on start)
//   done          high in the last iteration cycle
//   product       final 2*WIDTH product, valid while done is high
// ---------------------------------------------------------------------------
module alu_seq_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] acc_sum;

    // Accumulator value after this cycle's partial product.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == CNT_W'(1));
    assign product = acc_sum;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CNT_W'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked WIDTH-bit ALU with registered result and C/Z/V flags.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (alu_code, a, b)
//   out_valid / out_ready result handshake (result, flag_c, flag_z, flag_v)
// Non-MUL operations complete at the accept edge; MUL runs WIDTH extra
// cycles in alu_seq_mul. A completed result is held until taken, and a new
// operation may be accepted on the same edge the held result is taken.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           alu_code,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_c,
    output logic                 flag_z,
    output logic                 flag_v
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               c_q, c_d, z_q, z_d, v_q, v_d;
    logic               accept, is_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [MAX_W-1:0]   a_ext, b_ext;
    alu_out_t           comb_out;

    assign is_mul    = (alu_code == ALU_MUL);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;

    always_comb begin
        a_ext            = '0;
        b_ext            = '0;
        a_ext[WIDTH-1:0] = a;
        b_ext[WIDTH-1:0] = b;
        comb_out         = alu_comb(alu_code, a_ext, b_ext, 6'(WIDTH));
    end

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = is_mul ? MUL : HOLD;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_d = is_mul ? MUL : HOLD;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in HOLD a new op enters only as the old result leaves.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Result and flags. The upper container bits of comb_out are always
    // zero, so testing the whole vector gives the 2*WIDTH zero flag.
    always_comb begin
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        v_d      = v_q;
        if (accept && !is_mul) begin
            result_d = comb_out.result[2*WIDTH-1:0];
            c_d      = comb_out.c;
            v_d      = comb_out.v;
            z_d      = (comb_out.result == '0);
        end else if (mul_done) begin
            result_d = mul_product;
            c_d      = 1'b0;
            v_d      = 1'b0;
            z_d      = (mul_product == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            v_q      <= v_d;
        end
    end

    assign result = result_q;
    assign flag_c = c_q;
    assign flag_z = z_q;
    assign flag_v = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Bench for alu_seq at WIDTH=8 (directed table and handshake sequences) and
// WIDTH=16 (directed MUL plus a randomized stream scored against a plain
// integer-arithmetic reference model).
// ---------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, c8, z8, v8;
    logic [2:0]  code8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, c16, z16, v16;
    logic [2:0]  code16;
    logic [15:0] a16, b16;
    logic [31:0] res16;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_code(code8), .a(a8), .b(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(res8), .flag_c(c8), .flag_z(z8),
        .flag_v(v8));

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_code(code16), .a(a16), .b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .result(res16), .flag_c(c16), .flag_z(z16),
        .flag_v(v16));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        z;
        logic        v;
    } exp_t;

    // Reference: operands as plain integers, flags from arithmetic ranges.
    function automatic exp_t model(input int w, input logic [2:0] op, input longint a, input longint b);
        longint m, half, sa, sb, r;
        exp_t   e;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        e.c  = 1'b0;
        e.v  = 1'b0;
        case (op)
            ALU_ADD: begin
                r   = a + b;
                e.c = (r >= m);
                e.v = (sa + sb >= half) || (sa + sb < -half);
            end
            ALU_SUB: begin
                r   = ((a - b + m) % m) + ((a < b) ? m : 0);
                e.c = (a < b);
                e.v = (sa - sb >= half) || (sa - sb < -half);
            end
            ALU_MUL:  r = a * b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_NAND: r = ~(a & b) & (m - 1);
            ALU_NOR:  r = ~(a | b) & (m - 1);
            default:  r = a ^ b;
        endcase
        e.res = 64'(r);
        e.z   = (r == 0);
        return e;
    endfunction

    // lat = clock edges after the accept edge until out_valid is seen.
    task automatic op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic c, output logic z, output logic v,
                       output int lat, output bit busy_ok);
        int g;
        @(negedge clk);
        code8 = op; a8 = a; b8 = b; in_valid8 = 1'b1; out_ready8 = 1'b0;
        g = 0;
        while (!in_ready8 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); code8 = 3'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid8 && lat < 100) begin
            if (in_ready8) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        r = res8; c = c8; z = z8; v = v8;
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    task automatic op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] r, output int lat);
        @(negedge clk);
        code16 = op; a16 = a; b16 = b; in_valid16 = 1'b1; out_ready16 = 1'b0;
        @(negedge clk);
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!out_valid16 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = res16;
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        v;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r8;
        logic [31:0] r32;
        logic        fc, fz, fv;
        int          lat;
        bit          busy_ok, quiet;
        exp_t        q[$];
        exp_t        e;
        int          sent, got, cycles;
        bit          pend;

        tbl[0]  = '{ALU_ADD,  8'd200,  8'd100,  16'h012C, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{ALU_ADD,  8'd127,  8'd1,    16'h0080, 1'b0, 1'b0, 1'b1, 0};
        tbl[2]  = '{ALU_ADD,  8'd255,  8'd1,    16'h0100, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{ALU_SUB,  8'd5,    8'd7,    16'h01FE, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{ALU_SUB,  8'd9,    8'd9,    16'h0000, 1'b0, 1'b1, 1'b0, 0};
        tbl[5]  = '{ALU_SUB,  8'h80,   8'd1,    16'h007F, 1'b0, 1'b0, 1'b1, 0};
        tbl[6]  = '{ALU_MUL,  8'd255,  8'd255,  16'hFE01, 1'b0, 1'b0, 1'b0, 8};
        tbl[7]  = '{ALU_MUL,  8'd0,    8'h37,   16'h0000, 1'b0, 1'b1, 1'b0, 8};
        tbl[8]  = '{ALU_MUL,  8'h80,   8'h02,   16'h0100, 1'b0, 1'b0, 1'b0, 8};
        tbl[9]  = '{ALU_AND,  8'hF0,   8'h3C,   16'h0030, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{ALU_OR,   8'hF0,   8'h0F,   16'h00FF, 1'b0, 1'b0, 1'b0, 0};
        tbl[11] = '{ALU_NAND, 8'hFF,   8'hFF,   16'h0000, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{ALU_NOR,  8'h00,   8'h00,   16'h00FF, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{ALU_XOR,  8'hAA,   8'h55,   16'h00FF, 1'b0, 1'b0, 1'b0, 0};
        tbl[14] = '{ALU_XOR,  8'h5A,   8'h5A,   16'h0000, 1'b0, 1'b1, 1'b0, 0};

        in_valid8 = 0; out_ready8 = 0; code8 = 0; a8 = 0; b8 = 0;
        in_valid16 = 0; out_ready16 = 0; code16 = 0; a16 = 0; b16 = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready8",  in_ready8, 1);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_result8",    res8, 0);
        check("rst_flags8",     {c8, z8, v8}, 0);
        check("rst_in_ready16", in_ready16, 1);
        check("rst_out_valid16", out_valid16, 0);
        rst = 1'b0;

        // out_ready with nothing to deliver
        out_ready8 = 1'b1;
        @(negedge clk);
        check("idle_out_ready_valid", out_valid8, 0);
        check("idle_out_ready_inrdy", in_ready8, 1);
        out_ready8 = 1'b0;

        foreach (tbl[i]) begin
            op8(tbl[i].op, tbl[i].a, tbl[i].b, r8, fc, fz, fv, lat, busy_ok);
            check($sformatf("vec%0d_result", i), r8, tbl[i].res);
            check($sformatf("vec%0d_c", i), fc, tbl[i].c);
            check($sformatf("vec%0d_z", i), fz, tbl[i].z);
            check($sformatf("vec%0d_v", i), fv, tbl[i].v);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            if (tbl[i].lat > 0) check($sformatf("vec%0d_busy_in_ready", i), busy_ok, 1);
        end

        // XOR then NOR back-to-back with the consumer stalled for 3 cycles
        @(negedge clk);
        code8 = ALU_XOR; a8 = 8'hF0; b8 = 8'hFF; in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        code8 = ALU_NOR; a8 = 8'h00; b8 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_valid", i), out_valid8, 1);
            check($sformatf("stall%0d_result", i), res8, 16'h000F);
            check($sformatf("stall%0d_in_ready", i), in_ready8, 0);
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        #1;
        check("release_in_ready", in_ready8, 1);
        check("release_result", res8, 16'h000F);
        @(negedge clk);
        in_valid8 = 1'b0; out_ready8 = 1'b0;
        check("nor_valid", out_valid8, 1);
        check("nor_result", res8, 16'h00FF);
        check("nor_z", z8, 0);
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("nor_drained", out_valid8, 0);

        // Reset in the fourth MUL cycle discards the operation
        @(negedge clk);
        code8 = ALU_MUL; a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midmul_rst_valid", out_valid8, 0);
        check("midmul_rst_in_ready", in_ready8, 1);
        check("midmul_rst_result", res8, 0);
        check("midmul_rst_flags", {c8, z8, v8}, 0);
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid8) quiet = 1'b0;
        end
        check("midmul_no_output", quiet, 1);
        op8(ALU_ADD, 8'd1, 8'd1, r8, fc, fz, fv, lat, busy_ok);
        check("post_rst_add", r8, 16'h0002);
        check("post_rst_add_lat", lat, 0);

        // WIDTH=16 directed multiply
        op16(ALU_MUL, 16'hFFFF, 16'h0002, r32, lat);
        check("w16_mul_result", r32, 32'h0001FFFE);
        check("w16_mul_latency", lat, 16);

        // WIDTH=16 random stream with random back-pressure
        sent = 0; got = 0; cycles = 0; pend = 1'b0;
        while (got < 1000 && cycles < 40000) begin
            @(negedge clk);
            cycles++;
            if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
                code16 = 3'($urandom); a16 = pick16(); b16 = pick16();
                in_valid16 = 1'b1;
                pend = 1'b1;
            end else if (!pend) begin
                in_valid16 = 1'b0;
            end
            out_ready16 = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid16 && out_ready16) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("rand%0d_result", got), res16, e.res);
                    check($sformatf("rand%0d_c", got), c16, e.c);
                    check($sformatf("rand%0d_z", got), z16, e.z);
                    check($sformatf("rand%0d_v", got), v16, e.v);
                    got++;
                end
            end
            if (in_valid16 && in_ready16) begin
                q.push_back(model(16, code16, longint'(a16), longint'(b16)));
                sent++;
                pend = 1'b0;
            end
        end
        check("rand_completed", got, 1000);
        in_valid16 = 1'b0; out_ready16 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
